// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, glitch-start
// rejection and framing-error detection at CLKS_PER_BIT clocks per bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_serial,
  output logic       o_rx_dv,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_busy,
  output logic       o_frame_err,
  output logic [1:0] o_dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] clk_count_q, clk_count_d;
  logic [2:0]    bit_index_q, bit_index_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_dv_q, rx_dv_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic          stop_sample;

  // State register, including the synchroniser (idle-high at reset).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      clk_count_q <= '0;
      bit_index_q <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= i_rx_serial;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_dv_q     <= rx_dv_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    case (state_q)
      IDLE: begin
        clk_count_d = '0;
        bit_index_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // Re-check the line at mid start bit; still high means a glitch.
        if (clk_count_q == HALF) begin
          clk_count_d = '0;
          state_d     = rx_s_q ? IDLE : DATA;
        end else begin
          clk_count_d = clk_count_q + CW'(1);
        end
      end
      DATA: begin
        if (clk_count_q == LAST) begin
          clk_count_d          = '0;
          shift_d[bit_index_q] = rx_s_q;
          if (bit_index_q == 3'd7) begin
            bit_index_d = '0;
            state_d     = STOP;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end else begin
          clk_count_d = clk_count_q + CW'(1);
        end
      end
      STOP: begin
        // Leaving at mid stop bit lets a back-to-back start be caught.
        if (clk_count_q == LAST) begin
          clk_count_d = '0;
          state_d     = IDLE;
        end else begin
          clk_count_d = clk_count_q + CW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        clk_count_d = '0;
        bit_index_d = '0;
      end
    endcase
  end

  // Output logic: pulses at the stop-bit sample, busy follows next state.
  always_comb begin
    stop_sample = (state_q == STOP) && (clk_count_q == LAST);
    rx_dv_d     = stop_sample && rx_s_q;
    frame_err_d = stop_sample && !rx_s_q;
    rx_byte_d   = rx_dv_d ? shift_q : rx_byte_q;
    busy_d      = (state_d != IDLE);
  end

  assign o_rx_dv     = rx_dv_q;
  assign o_rx_byte   = rx_byte_q;
  assign o_rx_busy   = busy_q;
  assign o_frame_err = frame_err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a behavioural serial driver predicts each receive
// event (kind, byte, edge) into queues checked by a negedge monitor.
module tb_uart_rx;

  localparam int CPB      = 16;
  localparam int HALF     = (CPB - 1) / 2;
  // Edge k after edge 1 lies k-1 cycles on; stop sample is edge HALF+4+9*CPB.
  localparam int STOP_OFS = HALF + 3 + 9 * CPB;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_rx_serial = 1'b1;
  logic       o_rx_dv;
  logic [7:0] o_rx_byte;
  logic       o_rx_busy;
  logic       o_frame_err;
  logic [1:0] o_dbg_state;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx_serial (i_rx_serial),
    .o_rx_dv     (o_rx_dv),
    .o_rx_byte   (o_rx_byte),
    .o_rx_busy   (o_rx_busy),
    .o_frame_err (o_frame_err),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [1:0] exp_kind_q[$];   // 2'b10 = byte received, 2'b01 = framing error
  int         exp_cyc_q[$];
  logic [7:0] last_good = 8'h00;
  logic       busy_prev = 1'b0;

  always @(negedge i_clk) begin
    if (i_rst && (o_rx_dv || o_frame_err)) begin
      logic [7:0] eb;
      logic [1:0] ek;
      int         ec;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: dv=%0b err=%0b byte=%02h at cycle %0d, none expected",
                 o_rx_dv, o_frame_err, o_rx_byte, cyc);
      end else begin
        eb = exp_q.pop_front();
        ek = exp_kind_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if ({o_rx_dv, o_frame_err} !== ek || o_rx_byte !== eb || cyc != ec ||
            o_rx_busy !== 1'b0 || busy_prev !== 1'b1) begin
          fails++;
          $display("FAIL rx_event: got dv/err=%02b byte=%02h cyc=%0d busy=%0b prev_busy=%0b, expected dv/err=%02b byte=%02h cyc=%0d busy=0 prev_busy=1",
                   {o_rx_dv, o_frame_err}, o_rx_byte, cyc, o_rx_busy, busy_prev, ek, eb, ec);
        end
      end
    end
    busy_prev <= o_rx_busy;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge i_clk);
      #1;
    end
  endtask

  // Called just after a rising edge; the first low bit is captured at the next edge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    int         start;
    bits  = {stop, b, 1'b0};
    start = cyc + 1;
    if (stop) begin
      last_good = b;
      exp_q.push_back(b);
      exp_kind_q.push_back(2'b10);
    end else begin
      exp_q.push_back(last_good);
      exp_kind_q.push_back(2'b01);
    end
    exp_cyc_q.push_back(start + STOP_OFS);
    for (int i = 0; i < 10; i++) begin
      i_rx_serial = bits[i];
      repeat (CPB) @(posedge i_clk);
      #1;
    end
    i_rx_serial = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b0;
    i_rx_serial = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    tests++;
    if ({o_rx_dv, o_rx_byte, o_rx_busy, o_frame_err, o_dbg_state} !== 13'h0) begin
      fails++;
      $display("FAIL reset_values: dv=%0b byte=%02h busy=%0b err=%0b state=%0d, expected all zero",
               o_rx_dv, o_rx_byte, o_rx_busy, o_frame_err, o_dbg_state);
    end
    i_rst = 1'b1;
    last_good = 8'h00;
    idle(2 * CPB);
    tests++;
    if (o_rx_busy !== 1'b0 || o_rx_byte !== 8'h00) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%0b byte=%02h, expected 0 and 00", o_rx_busy, o_rx_byte);
    end
  endtask

  task automatic test_single();
    send_frame(8'h41, 1'b1);
    idle(CPB);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL single_pending: %0d events missing, expected 0", exp_q.size());
      exp_q.delete(); exp_kind_q.delete(); exp_cyc_q.delete();
    end
    tests++;
    if (o_rx_byte !== 8'h41) begin
      fails++;
      $display("FAIL single_hold: byte=%02h, expected 41", o_rx_byte);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA5, 1'b1);
    idle(CPB);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_pending: %0d events missing, expected 0", exp_q.size());
      exp_q.delete(); exp_kind_q.delete(); exp_cyc_q.delete();
    end
    tests++;
    if (o_rx_byte !== 8'hA5) begin
      fails++;
      $display("FAIL b2b_hold: byte=%02h, expected a5", o_rx_byte);
    end
  endtask

  task automatic test_glitch();
    int start, rise, fall, glen;
    glen  = HALF - 3;
    start = cyc + 1;
    rise  = -1;
    fall  = -1;
    i_rx_serial = 1'b0;
    for (int k = 0; k < 3 * CPB; k++) begin
      @(posedge i_clk);
      #1;
      if (cyc - start + 1 == glen) i_rx_serial = 1'b1;
      if (rise < 0 && o_rx_busy === 1'b1) rise = cyc;
      if (rise >= 0 && fall < 0 && o_rx_busy === 1'b0) fall = cyc;
    end
    tests++;
    if (rise != start + 2) begin
      fails++;
      $display("FAIL glitch_busy_rise: cycle %0d, expected %0d", rise, start + 2);
    end
    tests++;
    if (fall != start + HALF + 3) begin
      fails++;
      $display("FAIL glitch_busy_fall: cycle %0d, expected %0d", fall, start + HALF + 3);
    end
    send_frame(8'h3C, 1'b1);
    idle(CPB);
    tests++;
    if (exp_q.size() != 0 || o_rx_byte !== 8'h3C) begin
      fails++;
      $display("FAIL glitch_followup: pending=%0d byte=%02h, expected 0 and 3c", exp_q.size(), o_rx_byte);
      exp_q.delete(); exp_kind_q.delete(); exp_cyc_q.delete();
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'h55, 1'b1);
    send_frame(8'h12, 1'b0);
    idle(2 * CPB);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL frame_err_pending: %0d events missing, expected 0", exp_q.size());
      exp_q.delete(); exp_kind_q.delete(); exp_cyc_q.delete();
    end
    tests++;
    if (o_rx_byte !== 8'h55) begin
      fails++;
      $display("FAIL frame_err_hold: byte=%02h, expected 55", o_rx_byte);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    bits = {1'b1, 8'h81, 1'b0};
    for (int i = 0; i < 5; i++) begin
      i_rx_serial = bits[i];
      repeat (CPB) @(posedge i_clk);
      #1;
    end
    i_rx_serial = bits[5];
    repeat (CPB / 2) @(posedge i_clk);
    #1;
    tests++;
    if (o_rx_busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_busy_before: busy=%0b, expected 1", o_rx_busy);
    end
    i_rst = 1'b0;
    #1;
    tests++;
    if ({o_rx_dv, o_rx_byte, o_rx_busy, o_frame_err, o_dbg_state} !== 13'h0) begin
      fails++;
      $display("FAIL reset_mid_values: dv=%0b byte=%02h busy=%0b err=%0b state=%0d, expected all zero",
               o_rx_dv, o_rx_byte, o_rx_busy, o_frame_err, o_dbg_state);
    end
    i_rx_serial = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    last_good = 8'h00;
    idle(2 * CPB);
    send_frame(8'h7E, 1'b1);
    idle(CPB);
    tests++;
    if (exp_q.size() != 0 || o_rx_byte !== 8'h7E) begin
      fails++;
      $display("FAIL reset_mid_followup: pending=%0d byte=%02h, expected 0 and 7e", exp_q.size(), o_rx_byte);
      exp_q.delete(); exp_kind_q.delete(); exp_cyc_q.delete();
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    logic       prev_err;
    prev_err = 1'b0;
    for (int n = 0; n < 40; n++) begin
      // After a low stop bit the line must be high long enough to reject the tail.
      if (prev_err) idle(CPB + $urandom_range(0, CPB));
      else          idle($urandom_range(0, 3));
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      prev_err = !stop;
    end
    idle(2 * CPB);
    tests++;
    if (exp_q.size() != 0 || o_rx_byte !== last_good) begin
      fails++;
      $display("FAIL random_final: pending=%0d byte=%02h, expected 0 and %02h", exp_q.size(), o_rx_byte, last_good);
      exp_q.delete(); exp_kind_q.delete(); exp_cyc_q.delete();
    end
  endtask

  task automatic test_loopback();
    logic [7:0] vals[256];
    logic [7:0] tmp;
    int         j;
    for (int i = 0; i < 256; i++) vals[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j       = $urandom_range(0, i);
      tmp     = vals[i];
      vals[i] = vals[j];
      vals[j] = tmp;
    end
    for (int i = 0; i < 256; i++) send_frame(vals[i], 1'b1);
    idle(CPB);
    tests++;
    if (exp_q.size() != 0 || o_rx_byte !== vals[255]) begin
      fails++;
      $display("FAIL loopback_final: pending=%0d byte=%02h, expected 0 and %02h", exp_q.size(), o_rx_byte, vals[255]);
      exp_q.delete(); exp_kind_q.delete(); exp_cyc_q.delete();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver for the loopback design. It samples `i_rx_serial` at the centre of each bit and deserialises 8N1 frames (LSB first, no parity, 1 stop bit) at `CLKS_PER_BIT` clocks per bit. Each received byte is presented with a one-cycle valid strobe to the display and transmit logic. It also detects glitch start bits and framing errors.

## Interface
- `CLKS_PER_BIT`, 217, i_clk cycles per bit; 25 MHz / 115200 baud. Legal range ≥ 4.
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_rst`  in  1  asynchronous, active-low reset.
- `i_rx_serial`  in  1  asynchronous serial line; idles high.
- `o_rx_dv`  out  1  one-cycle pulse; `o_rx_byte` is valid in the same cycle.
- `o_rx_byte`  out  8  last correctly framed byte; held until the next good frame.
- `o_rx_busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `o_frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- **Synchroniser:** two flops on `i_rx_serial`. Both reset to 1. All decisions use the second flop (`rx_s`).
- **Definitions:** HALF = (CLKS_PER_BIT-1)/2, integer division; 108 at the default. `clk_count` is wide enough to hold CLKS_PER_BIT-1. `bit_index` is 3 bits.
- **States:** IDLE, START, DATA, STOP.
- **IDLE**
  - `clk_count` = 0, `bit_index` = 0.
  - If `rx_s` == 0, go to START.
- **START**
  - Increment `clk_count` until it equals HALF.
  - At HALF: if `rx_s` == 0, go to DATA with `clk_count` = 0.
  - At HALF: if `rx_s` == 1, the start bit was a glitch; go to IDLE with no outputs pulsed.
- **DATA**
  - Increment `clk_count` until it equals CLKS_PER_BIT-1.
  - At CLKS_PER_BIT-1: shift register bit[`bit_index`] ← `rx_s` and set `clk_count` = 0.
  - If `bit_index` < 7, increment `bit_index`; otherwise set `bit_index` = 0 and go to STOP.
- **STOP**
  - Increment `clk_count` until it equals CLKS_PER_BIT-1, then sample `rx_s`.
  - If `rx_s` == 1: `o_rx_byte` ← shift register and `o_rx_dv` ← 1.
  - If `rx_s` == 0: `o_frame_err` ← 1 and `o_rx_byte` is unchanged.
  - In both cases go to IDLE.
- **Early return to IDLE:** IDLE is re-entered at mid-stop-bit. The second half of the stop bit is high, so there is no false start, and back-to-back frames with no idle gap are received correctly.
- **Register updates:** the internal shift register updates during DATA. `o_rx_byte` updates only on a good stop bit.
- **Output pulses:** `o_rx_dv` and `o_frame_err` are cleared every cycle unless set as above. They are never high together.
- **`o_rx_busy`:** registered; high in START, DATA and STOP.
- **Unreachable state encodings:** go to IDLE.

## Timing
- **Reset values:** `o_rx_dv` = 0, `o_rx_byte` = 8'h00, `o_rx_busy` = 0, `o_frame_err` = 0, state = IDLE, counters = 0, synchroniser = 1.
- **Reset mid-frame:** abort immediately. No `o_rx_dv` or `o_frame_err` pulse; `o_rx_byte` returns to 0.
- **Edge numbering:** edge 1 is the first rising edge at which the input flop captures the low start bit.
- **Sequence from edge 1:**
  - Edge 3: state ← START.
  - Edge HALF+4: START→DATA decision (112 at the default).
  - Data bit k is sampled at edge HALF+4+(k+1)·CLKS_PER_BIT; bit 0 at edge 329 at the default.
  - Stop bit is sampled and `o_rx_dv`/`o_frame_err` set at edge HALF+4+9·CLKS_PER_BIT (2065 at the default). The pulse clears at the next edge.
- **Glitch filter:** a low pulse shorter than about HALF cycles is rejected. `o_rx_busy` falls at edge HALF+4.
- **Handshake:** no back-pressure. The consumer must capture `o_rx_byte` on `o_rx_dv`, and the byte stays stable until the next good frame (at least 10·CLKS_PER_BIT-HALF cycles later).
- **Baud tolerance:** mid-bit sampling tolerates about ±4% baud mismatch at the default.

## Test plan
- **Single byte:** send 0x41 at 217 clk/bit → `o_rx_dv` pulses for exactly 1 cycle at edge 2065 with `o_rx_byte` = 0x41. `o_frame_err` stays 0 and `o_rx_busy` falls with the pulse.
- **Back-to-back frames:** send 0x00, 0xFF, 0xA5 with no idle gap → three `o_rx_dv` pulses exactly 2170 cycles apart, carrying 0x00, 0xFF, 0xA5.
- **Glitch rejection:** drive a 50-cycle low pulse on an idle line → no `o_rx_dv` and no `o_frame_err`. `o_rx_busy` is high from edge 3 to edge 112, and a following 0x3C is still received correctly.
- **Framing error:** receive 0x55, then send 0x12 with the stop bit held low → one `o_frame_err` pulse at the stop sample, no `o_rx_dv`, and `o_rx_byte` stays 0x55.
- **Reset mid-frame:** assert `i_rst` low during data bit 4 of 0x81 → outputs go to their reset values and no pulse occurs. After release, 0x7E is received correctly.
- **Loopback:** connect the UART transmitter's serial output to `i_rx_serial` and send all 256 byte values → each `o_rx_byte` equals the transmitted byte, and `o_frame_err` is never asserted.
